// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared width, opcode encoding and divide-by-zero constant
//               for the 8-bit registered ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH = 8;

    // Operation select codes; all eight encodings are defined.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    // Quotient returned when dividing by zero.
    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu8_if.sv
`default_nettype none
// ============================================================================
// Module      : alu8_if
// Description : Operand/control/result bundle of the registered ALU.
//               The master drives operands and control and samples the result.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu8_if #(
    parameter int WIDTH = alu_pkg::WIDTH
);
    logic [2:0]       ctrl_i;
    logic [WIDTH-1:0] data0_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] result_o;

    modport master (
        output ctrl_i,
        output data0_i,
        output data1_i,
        input  result_o
    );

    modport slave (
        input  ctrl_i,
        input  data0_i,
        input  data1_i,
        output result_o
    );
endinterface : alu8_if
`default_nettype wire

// File: rtl/alu_divmod.sv
`default_nettype none
// ============================================================================
// Module      : alu_divmod
// Description : Combinational unsigned restoring divider, WIDTH stages.
//               One instance yields both quotient and remainder; a zero
//               divisor returns the all-ones quotient and the dividend as
//               remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_divmod
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  wire logic [WIDTH-1:0] i_dividend,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_quotient,
    output logic      [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;

    // Restoring long division, MSB first: shift in one dividend bit per stage,
    // keep the subtraction only when it does not borrow. The partial remainder
    // is always below the divisor, so WIDTH bits hold it and WIDTH+1 bits hold
    // the trial value.
    always_comb begin
        w_quo   = '0;
        w_rem   = '0;
        w_trial = '0;
        w_diff  = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_trial = {w_rem, i_dividend[i]};
            w_diff  = w_trial - {1'b0, i_divisor};
            if (!w_diff[WIDTH]) begin
                w_quo[i] = 1'b1;
                w_rem    = w_diff[WIDTH-1:0];
            end else begin
                w_rem    = w_trial[WIDTH-1:0];
            end
        end
    end

    // Zero divisor is a defined case rather than an error.
    always_comb begin
        if (i_divisor == '0) begin
            o_quotient  = WIDTH'(DIV_ZERO_RESULT);
            o_remainder = i_dividend;
        end else begin
            o_quotient  = w_quo;
            o_remainder = w_rem;
        end
    end

endmodule : alu_divmod
`default_nettype wire

// File: rtl/alu8_top.sv
`default_nettype none
// ============================================================================
// Module      : alu8_top
// Description : 8-bit unsigned ALU with eight operations and a registered
//               result (1-cycle latency, new operation every cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module alu8_top
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    alu8_if.slave     bus
);

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_result;

    assign w_op = alu_op_e'(bus.ctrl_i);

    alu_divmod #(
        .WIDTH (WIDTH)
    ) u_divmod (
        .i_dividend  (bus.data0_i),
        .i_divisor   (bus.data1_i),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder)
    );

    // Opcode mux; every result is naturally truncated to WIDTH bits.
    always_comb begin
        w_next = '0;
        unique case (w_op)
            OP_ADD: w_next = bus.data0_i + bus.data1_i;
            OP_SUB: w_next = bus.data0_i - bus.data1_i;
            OP_MUL: w_next = bus.data0_i * bus.data1_i;
            OP_DIV: w_next = w_quotient;
            OP_MOD: w_next = w_remainder;
            OP_AND: w_next = bus.data0_i & bus.data1_i;
            OP_OR : w_next = bus.data0_i | bus.data1_i;
            OP_XOR: w_next = bus.data0_i ^ bus.data1_i;
        endcase
    end

    // Result register; reset wins over the operation sampled at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else begin
            r_result <= w_next;
        end
    end

    assign bus.result_o = r_result;

endmodule : alu8_top
`default_nettype wire

// File: tb/tb_alu8_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu8_top
// Description : Directed and randomized bench for alu8_top with an expected-
//               value queue checked one cycle after each stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu8_top;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } sb_entry_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    sb_entry_t sb[$];

    alu8_if u_if ();

    alu8_top dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent integer reference of the operation table.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    return 8'((ia + ib) % 256);
            3'd1:    return 8'((ia - ib + 256) % 256);
            3'd2:    return 8'((ia * ib) % 256);
            3'd3:    return (ib == 0) ? 8'hFF : 8'(ia / ib);
            3'd4:    return (ib == 0) ? a : 8'(ia % ib);
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check_one();
        sb_entry_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty got=%0h exp=<entry>", u_if.result_o);
        end else begin
            e = sb.pop_front();
            assert (u_if.result_o === e.exp)
            else begin
                bad++;
                $error("FAIL %s got=%0h exp=%0h", e.tag, u_if.result_o, e.exp);
            end
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, check just after the edge.
    task automatic step(input logic r, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input string tag);
        rst        = r;
        u_if.ctrl_i  = op;
        u_if.data0_i = a;
        u_if.data1_i = b;
        sb.push_back('{exp, tag});
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       r;
        total = 0;
        bad   = 0;

        // Reset held two cycles, then first operation.
        step(1'b1, OP_ADD, 8'd10, 8'd1, 8'd0,  "reset_cycle1");
        step(1'b1, OP_ADD, 8'd10, 8'd1, 8'd0,  "reset_cycle2");
        step(1'b0, OP_ADD, 8'd10, 8'd1, 8'd11, "first_add");

        // Arithmetic, back to back.
        step(1'b0, OP_SUB, 8'd20, 8'd10, 8'd10, "sub_20_10");
        step(1'b0, OP_MUL, 8'd8,  8'd8,  8'd64, "mul_8_8");
        step(1'b0, OP_DIV, 8'd12, 8'd2,  8'd6,  "div_12_2");
        step(1'b0, OP_MOD, 8'd15, 8'd3,  8'd0,  "mod_15_3");

        // Inputs changing between edges must not disturb the held result.
        u_if.ctrl_i  = OP_ADD;
        u_if.data0_i = 8'd77;
        u_if.data1_i = 8'd1;
        #3;
        total++;
        assert (u_if.result_o === 8'd0)
        else begin
            bad++;
            $error("FAIL hold_between_edges got=%0h exp=%0h", u_if.result_o, 8'd0);
        end

        // Wrap-around.
        step(1'b0, OP_ADD, 8'd200, 8'd100, 8'd44,  "add_wrap");
        step(1'b0, OP_SUB, 8'd3,   8'd5,   8'd254, "sub_borrow");
        step(1'b0, OP_MUL, 8'd16,  8'd32,  8'd0,   "mul_16_32");
        step(1'b0, OP_MUL, 8'd255, 8'd255, 8'd1,   "mul_255_255");

        // Division edge cases.
        step(1'b0, OP_DIV, 8'd100, 8'd0, 8'd255, "div_by_zero");
        step(1'b0, OP_MOD, 8'd100, 8'd0, 8'd100, "mod_by_zero");
        step(1'b0, OP_DIV, 8'd7,   8'd9, 8'd0,   "div_7_9");
        step(1'b0, OP_MOD, 8'd7,   8'd9, 8'd7,   "mod_7_9");
        step(1'b0, OP_DIV, 8'd255, 8'd1, 8'd255, "div_255_1");

        // Logic ops.
        step(1'b0, OP_AND, 8'hCA, 8'h5F, 8'h4A, "and_ca_5f");
        step(1'b0, OP_OR,  8'hCA, 8'h5F, 8'hDF, "or_ca_5f");
        step(1'b0, OP_XOR, 8'hCA, 8'h5F, 8'h95, "xor_ca_5f");

        // Mid-stream one-cycle reset.
        step(1'b0, OP_ADD, 8'd1,  8'd2, 8'd3,  "pre_reset_add");
        step(1'b1, OP_MUL, 8'd9,  8'd9, 8'd0,  "midstream_reset");
        step(1'b0, OP_SUB, 8'd50, 8'd8, 8'd42, "post_reset_sub");

        // Randomized run against the reference model, occasional reset.
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            r  = ($urandom_range(0, 15) == 0);
            step(r, op, a, b, r ? 8'd0 : model(op, a, b), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu8_top
`default_nettype wire

// File: doc/alu8_top.md
# alu8_top

8-bit unsigned arithmetic/logic unit with a registered result. It selects one of eight operations through a 3-bit control code and applies it to two operands. The result register updates on every rising clock edge. The block is a leaf datapath element; the surrounding logic drives operands and control and samples `result_o` one cycle later.

## Interface
- `WIDTH`, default 8: operand and result width; all requirements below are stated for 8.
- `clk_i`  input  1  clock, rising-edge active.
- `rst_i`  input  1  reset, synchronous, active-high.
- `ctrl_i`  input  3  operation select.
- `data0_i`  input  WIDTH  operand A, unsigned.
- `data1_i`  input  WIDTH  operand B, unsigned.
- `result_o`  output  WIDTH  registered operation result.

## Operation
- All operands are unsigned. All results are truncated to the low WIDTH bits.
- 000 ADD: A + B, mod 256. The carry is discarded.
- 001 SUB: A − B, mod 256. On borrow the result wraps, e.g. 3 − 5 = 254.
- 010 MUL: low 8 bits of A × B; the upper byte is discarded.
- 011 DIV: floor(A / B).
- 100 MOD: A mod B.
- 101 AND: bitwise A & B.
- 110 OR: bitwise A | B.
- 111 XOR: bitwise A ^ B.
- Division by zero is not an error; no flag is raised.
  - DIV with B = 0 returns 8'hFF.
  - MOD with B = 0 returns A.
- No unknown codes exist; all eight encodings are defined.
- The combinational next-result is a pure function of `ctrl_i`, `data0_i` and `data1_i`, with no internal state beyond the output register.

## Timing
- `result_o` is registered; latency is 1 cycle.
  - Inputs sampled at rising edge N appear on `result_o` after edge N.
  - They hold until the next edge.
- A new operation may be issued every cycle. There is no handshake or valid signal, and no stall.
- Reset:
  - `rst_i` = 1 at a rising edge forces `result_o` to 0.
  - Reset overrides any operation in flight.
  - The first edge with `rst_i` = 0 loads the result of the inputs present at that edge.
- Divide and modulo complete combinationally within one cycle.
  - The divider path is the critical path.
  - It must close timing at the target clock without multicycle constraints.
- Operand or control changes between edges have no effect until the next edge.

## Structure
- Package `alu_pkg` holds:
  - the `WIDTH` default constant;
  - the 3-bit opcode type with named constants: `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`, `OP_MOD`, `OP_AND`, `OP_OR`, `OP_XOR`;
  - the divide-by-zero result constant 8'hFF.
- Sub-module `alu_divmod`:
  - combinational unsigned restoring divider, WIDTH stages;
  - produces quotient and remainder in one instance, shared by DIV and MOD;
  - handles B = 0 internally per the rules above.
- Top level contains the adder/subtractor, multiplier, logic ops, the opcode mux and the result register.

## Test plan
- Reset and first operation:
  - Assert `rst_i` for 2 cycles with A = 10, B = 1, ctrl 000 → `result_o` = 0.
  - Release reset → `result_o` = 11 after the next edge.
- Arithmetic, one operation per cycle:
  - ctrl 001 with 20, 10 → 10.
  - ctrl 010 with 8, 8 → 64.
  - ctrl 011 with 12, 2 → 6.
  - ctrl 100 with 15, 3 → 0.
  - Each result appears exactly 1 cycle after its inputs are applied.
- Wrap-around:
  - 200 + 100 → 44.
  - 3 − 5 → 254.
  - 16 × 32 → 0.
  - 255 × 255 → 1.
- Division edge cases:
  - 100 / 0 → 255.
  - 100 mod 0 → 100.
  - 7 / 9 → 0.
  - 7 mod 9 → 7.
  - 255 / 1 → 255.
- Logic ops, with A = 8'hCA and B = 8'h5F:
  - AND → 8'h4A.
  - OR → 8'hDF.
  - XOR → 8'h95.
- Mid-stream reset and randomized run:
  - Assert `rst_i` for one cycle during back-to-back operations → `result_o` = 0 for that cycle; the next cycle returns the current inputs' result.
  - Run randomized operands and opcodes against a reference model with 1-cycle latency.
